// File: rtl/dispense_motor_ctrl.sv
// Vending dispense sequencer: drives one spiral motor, watches the
// debounced drop sensor, coasts, then reports done or a coded fault.
module dispense_motor_ctrl #(
    parameter int unsigned MAX_RUN_CYC = 100_000_000,
    parameter int unsigned DEB_CYC     = 500_000,
    parameter int unsigned SETTLE_CYC  = 25_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req,
    input  logic [2:0] motor_id,
    input  logic       drop_n,
    input  logic       ack,
    output logic [5:0] motor_en,
    output logic       busy,
    output logic       done,
    output logic       fault,
    output logic [1:0] fault_code,
    output logic [2:0] active_id
);

    localparam int RW = $clog2(MAX_RUN_CYC + 1);
    localparam int SW = $clog2(SETTLE_CYC + 1);
    localparam int DW = $clog2(DEB_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_COAST,
        S_DONE,
        S_FAULT
    } state_t;

    state_t          state_q, state_d;
    logic [RW-1:0]   run_cnt_q, run_cnt_d;
    logic [SW-1:0]   set_cnt_q, set_cnt_d;
    logic [5:0]      motor_en_q, motor_en_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            fault_q, fault_d;
    logic [1:0]      code_q, code_d;
    logic [2:0]      id_q, id_d;

    logic            sync1_q, sync2_q;
    logic            drop_db_q, drop_db_d;
    logic [DW-1:0]   deb_cnt_q, deb_cnt_d;

    logic [5:0]      id_onehot;
    logic            id_valid;

    // Debounce: flip only after a run of samples disagreeing with drop_db
    always_comb begin
        drop_db_d = drop_db_q;
        deb_cnt_d = '0;
        if (sync2_q != drop_db_q) begin
            if (deb_cnt_q == DW'(DEB_CYC)) begin
                drop_db_d = sync2_q;
            end else begin
                deb_cnt_d = deb_cnt_q + 1'b1;
            end
        end
    end

    // Two-flop synchronizer and debounce state; sensor idles high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            drop_db_q <= 1'b1;
            deb_cnt_q <= '0;
        end else begin
            sync1_q   <= drop_n;
            sync2_q   <= sync1_q;
            drop_db_q <= drop_db_d;
            deb_cnt_q <= deb_cnt_d;
        end
    end

    // Motor number to one-hot drive pattern; 0 and 7 map to no motor
    always_comb begin
        id_onehot = 6'b000000;
        id_valid  = 1'b1;
        unique case (motor_id)
            3'd1:    id_onehot = 6'b000001;
            3'd2:    id_onehot = 6'b000010;
            3'd3:    id_onehot = 6'b000100;
            3'd4:    id_onehot = 6'b001000;
            3'd5:    id_onehot = 6'b010000;
            3'd6:    id_onehot = 6'b100000;
            default: id_valid  = 1'b0;
        endcase
    end

    // Next-state and next-output logic for the dispense sequence
    always_comb begin
        state_d    = state_q;
        run_cnt_d  = run_cnt_q;
        set_cnt_d  = set_cnt_q;
        motor_en_d = motor_en_q;
        busy_d     = busy_q;
        done_d     = done_q;
        fault_d    = fault_q;
        code_d     = code_q;
        id_d       = id_q;
        unique case (state_q)
            S_IDLE: begin
                if (req) begin
                    busy_d = 1'b1;
                    id_d   = motor_id;
                    if (!id_valid) begin
                        state_d = S_FAULT;
                        fault_d = 1'b1;
                        code_d  = 2'd1;
                    end else if (!drop_db_q) begin
                        state_d = S_FAULT;
                        fault_d = 1'b1;
                        code_d  = 2'd3;
                    end else begin
                        state_d    = S_RUN;
                        run_cnt_d  = '0;
                        motor_en_d = id_onehot;
                    end
                end
            end
            S_RUN: begin
                run_cnt_d = run_cnt_q + 1'b1;
                // A drop seen on the timeout cycle still counts as success
                if (!drop_db_q) begin
                    state_d    = S_COAST;
                    set_cnt_d  = '0;
                    motor_en_d = 6'b000000;
                end else if (run_cnt_q == RW'(MAX_RUN_CYC - 1)) begin
                    state_d    = S_FAULT;
                    motor_en_d = 6'b000000;
                    fault_d    = 1'b1;
                    code_d     = 2'd2;
                end
            end
            S_COAST: begin
                set_cnt_d = set_cnt_q + 1'b1;
                if (set_cnt_q == SW'(SETTLE_CYC - 1)) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end
            end
            S_DONE, S_FAULT: begin
                if (ack) begin
                    state_d    = S_IDLE;
                    motor_en_d = 6'b000000;
                    busy_d     = 1'b0;
                    done_d     = 1'b0;
                    fault_d    = 1'b0;
                    code_d     = 2'd0;
                    id_d       = 3'd0;
                end
            end
            default: begin
                state_d    = S_IDLE;
                motor_en_d = 6'b000000;
                busy_d     = 1'b0;
                done_d     = 1'b0;
                fault_d    = 1'b0;
                code_d     = 2'd0;
                id_d       = 3'd0;
            end
        endcase
    end

    // FSM state, counters and registered outputs; reset kills drive at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            run_cnt_q  <= '0;
            set_cnt_q  <= '0;
            motor_en_q <= 6'b000000;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            fault_q    <= 1'b0;
            code_q     <= 2'd0;
            id_q       <= 3'd0;
        end else begin
            state_q    <= state_d;
            run_cnt_q  <= run_cnt_d;
            set_cnt_q  <= set_cnt_d;
            motor_en_q <= motor_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            fault_q    <= fault_d;
            code_q     <= code_d;
            id_q       <= id_d;
        end
    end

    assign motor_en   = motor_en_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign fault      = fault_q;
    assign fault_code = code_q;
    assign active_id  = id_q;

endmodule

// File: tb/tb_dispense_motor_ctrl.sv
// Directed bench for dispense_motor_ctrl: table-driven fault paths
// plus hand-written dispense, jam, glitch, tie, busy and reset cases.
module tb_dispense_motor_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req;
    logic [2:0] motor_id;
    logic       drop_n;
    logic       ack;
    logic [5:0] motor_en;
    logic       busy;
    logic       done;
    logic       fault;
    logic [1:0] fault_code;
    logic [2:0] active_id;

    int total = 0;
    int passed = 0;

    dispense_motor_ctrl #(
        .MAX_RUN_CYC(100),
        .DEB_CYC(4),
        .SETTLE_CYC(10)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req(req),
        .motor_id(motor_id),
        .drop_n(drop_n),
        .ack(ack),
        .motor_en(motor_en),
        .busy(busy),
        .done(done),
        .fault(fault),
        .fault_code(fault_code),
        .active_id(active_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        req;
        logic [2:0]  id;
        logic        drop_n;
        logic        ack;
        int          n;
        logic [13:0] exp;
        string       name;
    } vec_t;

    function automatic logic [13:0] pk(input logic [5:0] m,
                                       input logic b,
                                       input logic d,
                                       input logic f,
                                       input logic [1:0] c,
                                       input logic [2:0] a);
        return {m, b, d, f, c, a};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [13:0] e);
        logic [13:0] got;
        got = {motor_en, busy, done, fault, fault_code, active_id};
        total++;
        if (got === e) passed++;
        else $display("FAIL %s: got en/busy/done/fault/code/id=%b required %b",
                      nm, got, e);
    endtask

    task automatic hold(input string nm, input int n, input logic [13:0] e);
        for (int i = 0; i < n; i++) begin
            tick();
            chk(nm, e);
        end
    endtask

    localparam logic [13:0] ZERO = 14'd0;

    vec_t vecs[10];

    initial begin
        vecs[0] = '{1'b1, 3'd0, 1'b1, 1'b0, 1, pk(6'd0, 1, 0, 1, 2'd1, 3'd0), "id0_fault"};
        vecs[1] = '{1'b0, 3'd0, 1'b1, 1'b0, 3, pk(6'd0, 1, 0, 1, 2'd1, 3'd0), "id0_hold"};
        vecs[2] = '{1'b0, 3'd0, 1'b1, 1'b1, 1, ZERO, "id0_ack"};
        vecs[3] = '{1'b1, 3'd7, 1'b1, 1'b0, 1, pk(6'd0, 1, 0, 1, 2'd1, 3'd7), "id7_fault"};
        vecs[4] = '{1'b0, 3'd7, 1'b1, 1'b1, 1, ZERO, "id7_ack"};
        vecs[5] = '{1'b0, 3'd2, 1'b0, 1'b0, 10, ZERO, "blocked_idle"};
        vecs[6] = '{1'b1, 3'd2, 1'b0, 1'b0, 1, pk(6'd0, 1, 0, 1, 2'd3, 3'd2), "blocked_fault"};
        vecs[7] = '{1'b0, 3'd2, 1'b1, 1'b0, 5, pk(6'd0, 1, 0, 1, 2'd3, 3'd2), "blocked_hold"};
        vecs[8] = '{1'b0, 3'd2, 1'b1, 1'b1, 1, ZERO, "blocked_ack"};
        vecs[9] = '{1'b0, 3'd0, 1'b1, 1'b0, 10, ZERO, "idle_settle"};

        rst_n = 1'b0;
        req = 1'b0;
        motor_id = 3'd0;
        drop_n = 1'b1;
        ack = 1'b0;
        #3;
        chk("reset_state", ZERO);
        #10;
        rst_n = 1'b1;
        hold("post_reset", 3, ZERO);

        // Invalid ids and blocked sensor
        foreach (vecs[i]) begin
            req = vecs[i].req;
            motor_id = vecs[i].id;
            drop_n = vecs[i].drop_n;
            ack = vecs[i].ack;
            hold(vecs[i].name, vecs[i].n, vecs[i].exp);
        end
        ack = 1'b0;
        req = 1'b0;

        // Normal dispense on motor 3
        req = 1'b1;
        motor_id = 3'd3;
        hold("run3_start", 1, pk(6'b000100, 1, 0, 0, 2'd0, 3'd3));
        req = 1'b0;
        motor_id = 3'd5;
        hold("run3_on", 29, pk(6'b000100, 1, 0, 0, 2'd0, 3'd3));
        drop_n = 1'b0;
        hold("run3_deb", 7, pk(6'b000100, 1, 0, 0, 2'd0, 3'd3));
        hold("run3_coast", 10, pk(6'd0, 1, 0, 0, 2'd0, 3'd3));
        hold("run3_done", 1, pk(6'd0, 1, 1, 0, 2'd0, 3'd3));
        hold("run3_done_hold", 2, pk(6'd0, 1, 1, 0, 2'd0, 3'd3));
        drop_n = 1'b1;
        hold("run3_done_hold2", 3, pk(6'd0, 1, 1, 0, 2'd0, 3'd3));
        ack = 1'b1;
        hold("run3_ack", 1, ZERO);
        ack = 1'b0;
        hold("run3_idle", 10, ZERO);

        // Jam on motor 6
        req = 1'b1;
        motor_id = 3'd6;
        hold("jam_start", 1, pk(6'b100000, 1, 0, 0, 2'd0, 3'd6));
        req = 1'b0;
        hold("jam_on", 99, pk(6'b100000, 1, 0, 0, 2'd0, 3'd6));
        hold("jam_fault", 1, pk(6'd0, 1, 0, 1, 2'd2, 3'd6));
        ack = 1'b1;
        hold("jam_ack", 1, ZERO);
        ack = 1'b0;
        hold("jam_idle", 2, ZERO);

        // Short glitch is filtered; the run ends in a jam timeout
        req = 1'b1;
        motor_id = 3'd5;
        hold("glitch_start", 1, pk(6'b010000, 1, 0, 0, 2'd0, 3'd5));
        req = 1'b0;
        hold("glitch_pre", 10, pk(6'b010000, 1, 0, 0, 2'd0, 3'd5));
        drop_n = 1'b0;
        hold("glitch_low", 3, pk(6'b010000, 1, 0, 0, 2'd0, 3'd5));
        drop_n = 1'b1;
        hold("glitch_after", 86, pk(6'b010000, 1, 0, 0, 2'd0, 3'd5));
        hold("glitch_timeout", 1, pk(6'd0, 1, 0, 1, 2'd2, 3'd5));
        ack = 1'b1;
        hold("glitch_ack", 1, ZERO);
        ack = 1'b0;

        // Drop lands on the last run cycle: drop wins
        req = 1'b1;
        motor_id = 3'd1;
        hold("tie_start", 1, pk(6'b000001, 1, 0, 0, 2'd0, 3'd1));
        req = 1'b0;
        hold("tie_on", 92, pk(6'b000001, 1, 0, 0, 2'd0, 3'd1));
        drop_n = 1'b0;
        hold("tie_deb", 7, pk(6'b000001, 1, 0, 0, 2'd0, 3'd1));
        hold("tie_coast", 1, pk(6'd0, 1, 0, 0, 2'd0, 3'd1));
        drop_n = 1'b1;
        hold("tie_coast2", 9, pk(6'd0, 1, 0, 0, 2'd0, 3'd1));
        hold("tie_done", 1, pk(6'd0, 1, 1, 0, 2'd0, 3'd1));
        ack = 1'b1;
        hold("tie_ack", 1, ZERO);
        ack = 1'b0;
        hold("tie_idle", 8, ZERO);

        // Requests during busy are ignored; held req restarts after ack
        req = 1'b1;
        motor_id = 3'd4;
        hold("busy_start", 1, pk(6'b001000, 1, 0, 0, 2'd0, 3'd4));
        req = 1'b0;
        hold("busy_run", 5, pk(6'b001000, 1, 0, 0, 2'd0, 3'd4));
        req = 1'b1;
        motor_id = 3'd1;
        hold("busy_req1", 1, pk(6'b001000, 1, 0, 0, 2'd0, 3'd4));
        req = 1'b0;
        hold("busy_run2", 3, pk(6'b001000, 1, 0, 0, 2'd0, 3'd4));
        req = 1'b1;
        hold("busy_req2", 2, pk(6'b001000, 1, 0, 0, 2'd0, 3'd4));
        req = 1'b0;
        drop_n = 1'b0;
        hold("busy_deb", 7, pk(6'b001000, 1, 0, 0, 2'd0, 3'd4));
        hold("busy_coast", 1, pk(6'd0, 1, 0, 0, 2'd0, 3'd4));
        drop_n = 1'b1;
        hold("busy_coast2", 9, pk(6'd0, 1, 0, 0, 2'd0, 3'd4));
        hold("busy_done", 1, pk(6'd0, 1, 1, 0, 2'd0, 3'd4));
        req = 1'b1;
        motor_id = 3'd4;
        ack = 1'b1;
        hold("repeat_ack", 1, ZERO);
        ack = 1'b0;
        hold("repeat_run", 1, pk(6'b001000, 1, 0, 0, 2'd0, 3'd4));
        req = 1'b0;
        hold("repeat_run2", 4, pk(6'b001000, 1, 0, 0, 2'd0, 3'd4));

        // Asynchronous reset mid-run
        #1;
        rst_n = 1'b0;
        #1;
        total++;
        if (motor_en === 6'd0) passed++;
        else $display("FAIL async_reset_en: got %b required 000000", motor_en);
        chk("async_reset_all", ZERO);
        #5;
        rst_n = 1'b1;
        hold("reset_release", 3, ZERO);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/dispense_motor_ctrl.md
# dispense_motor_ctrl

Sequences one vending dispense cycle. The LCD/menu state machine issues a request carrying a motor number. This block then:
- drives exactly one of six spiral motors;
- watches the product-drop sensor (debounced);
- lets the spiral coast;
- reports done or a coded fault back to the menu state machine.

It is the single owner of the motor drive lines, so no two motors can ever run together.

## Interface
Parameters:
- MAX_RUN_CYC, 100_000_000: motor on-time limit without a drop (2 s at 50 MHz).
- DEB_CYC, 500_000: cycles the drop sensor must stay stable before a change is accepted (10 ms).
- SETTLE_CYC, 25_000_000: coast time after a drop, motors off, before done (0.5 s).

Ports:
- clk  in  1  system clock, 50 MHz.
- rst_n  in  1  asynchronous active-low reset.
- req  in  1  dispense request, level; sampled only in IDLE.
- motor_id  in  3  motor number; valid values 1..6.
- drop_n  in  1  asynchronous drop sensor; 0 = product passing the beam.
- ack  in  1  acknowledges done/fault and returns the block to IDLE.
- motor_en  out  6  one-hot motor drive; bit k drives motor k+1.
- busy  out  1  high in every state except IDLE.
- done  out  1  dispense completed; held until ack.
- fault  out  1  dispense aborted; held until ack.
- fault_code  out  2  0 none, 1 invalid id, 2 run timeout (jam), 3 sensor blocked at request.
- active_id  out  3  latched motor_id of the current transaction; 0 in IDLE.

## Operation
- Reset values: all outputs 0; state IDLE; counters 0.
- Asserting rst_n=0 in any state clears motor_en immediately, without waiting for a clock edge.
- Sensor path:
  - drop_n goes through a 2-flop synchronizer, then a debouncer.
  - The debounced value drop_db changes only after DEB_CYC consecutive synchronized samples that differ from the current drop_db.
  - drop_db resets to 1.
- States:
  - IDLE
    - On req=1 with motor_id in 1..6 and drop_db=1: latch the id into active_id, clear run_cnt, go to RUN.
    - On req=1 with motor_id 0 or 7: go to FAULT with code 1.
    - On req=1 with a valid id but drop_db=0: go to FAULT with code 3.
    - A fault latches active_id=motor_id; no motor is driven.
  - RUN
    - motor_en[active_id-1]=1; all other bits 0. run_cnt increments.
    - On drop_db=0: go to COAST.
    - Else when run_cnt reaches MAX_RUN_CYC-1: go to FAULT with code 2.
    - If both conditions hold in the same cycle, the drop wins and the block goes to COAST.
  - COAST
    - motor_en=0. set_cnt counts from 0.
    - At SETTLE_CYC-1: go to DONE. Drop-sensor activity is ignored here.
  - DONE: done=1, motor_en=0. On ack=1: go to IDLE.
  - FAULT: fault=1, fault_code held, motor_en=0. On ack=1: go to IDLE.
- In IDLE, active_id, done, fault and fault_code are 0.
- req is ignored while busy. motor_id is sampled only on the accept cycle; later changes have no effect.
- ack is ignored outside DONE and FAULT.
- If req is still high on the cycle after returning to IDLE, a new transaction is accepted. Upstream must drop req before issuing ack if it does not want a repeat.

## Timing
- Request accepted at edge N (state IDLE, req=1): state is RUN and motor_en is high from edge N+1. All outputs are registered.
- Debounce: if drop_n falls before edge M and stays low, drop_db falls at edge M+2+DEB_CYC. State becomes COAST and motor_en falls at edge M+3+DEB_CYC.
- Timeout: with no drop, motor_en is high for exactly MAX_RUN_CYC cycles, then fault=1 and fault_code=2 on the same edge that motor_en falls.
- Coast: done rises exactly SETTLE_CYC cycles after motor_en falls.
- ack: sampled at edge K; done/fault/busy/active_id are 0 from edge K+1.
- Invalid-id or blocked-sensor fault: fault=1 one cycle after req is sampled; motor_en never asserts.

## Test plan
Bench parameters: MAX_RUN_CYC=100, DEB_CYC=4, SETTLE_CYC=10.

1. Normal dispense:
   - Stimulus: req=1, motor_id=3; drop_n low for 20 cycles starting 30 cycles later.
   - Required: motor_en=6'b000100 from N+1 until 7 cycles after drop_n falls; done=1 exactly 10 cycles later; ack → all outputs 0.
2. Jam:
   - Stimulus: motor_id=6, drop_n held 1.
   - Required: motor_en=6'b100000 for exactly 100 cycles, then fault=1, fault_code=2; ack clears.
3. Invalid id and blocked sensor:
   - Stimulus: motor_id=0, then motor_id=7, then motor_id=2 with drop_n held 0 for 10 cycles beforehand.
   - Required: fault_code=1, 1, 3 respectively; motor_en stays 0 throughout.
4. Glitch and tie:
   - Stimulus: 3-cycle drop_n pulse during RUN.
   - Required: pulse is ignored and the run continues.
   - Stimulus: drop_n timed so drop_db falls on run_cnt=99.
   - Required: COAST then done, with no fault.
5. Request during busy:
   - Stimulus: req pulses with motor_id=1 during RUN of motor 4.
   - Required: no change to motor_en or active_id.
   - Stimulus: req held high through ack.
   - Required: a new RUN starts on the cycle after IDLE.
6. Reset mid-run:
   - Stimulus: rst_n=0 between clock edges during RUN.
   - Required: motor_en=0 with no clock edge; after release, the block is in IDLE with all outputs 0.
